clz2_pipe: RTL and testbench

//  Registered array of 2-bit count-leading-zeros (CLZ) units.
//  It is the leaf stage of the FPU normalisation tree.

---
 rtl/clz2_pkg.sv | 20 ++
 rtl/clz2_lane.sv | 13 +
 rtl/clz2_pipe.sv | 75 +++++++
 tb/tb_clz2_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clz2_pkg.sv
// Shared constants and helpers for the 2-bit CLZ leaf stage and its merge logic.
package clz2_pkg;

  localparam int CLZ2_W = 2;

  function automatic logic [CLZ2_W-1:0] clz2(input logic [CLZ2_W-1:0] d);
    case (d)
      2'b00:   return 2'd2;
      2'b01:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Pairwise merge used by wider CLZ stages: the low count only matters when hi is all-zero.
  function automatic logic [CLZ2_W:0] merge2(input logic [CLZ2_W-1:0] hi,
                                             input logic [CLZ2_W-1:0] lo);
    return hi[1] ? ({1'b0, hi} + {1'b0, lo}) : {1'b0, hi};
  endfunction

endpackage

// File: rtl/clz2_lane.sv
// Combinational single-lane 2-bit count-leading-zeros.
module clz2_lane
  import clz2_pkg::*;
(
  input  logic [CLZ2_W-1:0] d,
  output logic [CLZ2_W-1:0] cnt,
  output logic              zero
);

  assign cnt  = clz2(d);
  assign zero = (d == 2'b00);

endmodule

// File: rtl/clz2_pipe.sv
// Registered array of 2-bit CLZ lanes behind a one-deep valid/ready register.
// Optional CLZ2_PIPE_MERGE_EN adds out_total, the leading-zero count of the whole word.
module clz2_pipe
  import clz2_pkg::*;
#(
  parameter int LANES = 8,
  localparam int TW   = $clog2(2*LANES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*LANES-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*LANES-1:0]   out_cnt,
  output logic [LANES-1:0]     out_zero,
`ifdef CLZ2_PIPE_MERGE_EN
  output logic [TW-1:0]        out_total,
`endif
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [2*LANES-1:0] cnt_d;
  logic [LANES-1:0]   zero_d;
  logic               accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    clz2_lane u_lane (
      .d    (in_data[2*i +: 2]),
      .cnt  (cnt_d[2*i +: 2]),
      .zero (zero_d[i])
    );
  end

  // Handshake: a beat moves on an edge where valid && ready. The output register
  // accepts a new beat whenever it is empty or being drained in the same cycle,
  // and holds its contents (with in_ready low) while out_valid && !out_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_zero  <= '0;
    end else begin
      out_valid <= accept || (out_valid && !out_ready);
      if (accept) begin
        out_cnt  <= cnt_d;
        out_zero <= zero_d;
      end
    end
  end

`ifdef CLZ2_PIPE_MERGE_EN
  logic [TW-1:0] total_d;
  logic          above_zero;

  // Scan from the most significant lane; a lane contributes only while every lane above it is empty.
  always_comb begin
    total_d    = '0;
    above_zero = 1'b1;
    for (int i = LANES-1; i >= 0; i--) begin
      if (above_zero) total_d = total_d + TW'(cnt_d[2*i +: 2]);
      above_zero = above_zero & zero_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_total <= '0;
    else if (accept) out_total <= total_d;
  end
`endif

endmodule

// File: tb/tb_clz2_pipe.sv
// Directed scoreboard bench for clz2_pipe (LANES=8); out_total is checked when CLZ2_PIPE_MERGE_EN is defined.
module tb_clz2_pipe;

  localparam int LANES = 8;
  localparam int DW    = 2*LANES;
  localparam int TW    = $clog2(2*LANES+1);
  localparam int EW    = DW + LANES + TW;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [DW-1:0]    cnt;
    logic [LANES-1:0] zero;
    logic [TW-1:0]    total;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    out_cnt;
  logic [LANES-1:0] out_zero;
  logic             out_valid;
  logic             out_ready;
`ifdef CLZ2_PIPE_MERGE_EN
  logic [TW-1:0]    out_total;
`endif

  vec_t          vecs [9];
  logic [EW-1:0] exp_q [$];
  int            checks;
  int            failures;
  int            pops;
  int            cyc;

  clz2_pipe #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero),
`ifdef CLZ2_PIPE_MERGE_EN
    .out_total (out_total),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per beat the DUT hands over.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", out_cnt);
      end else begin
        e = exp_q.pop_front();
        check("out_cnt", 32'(out_cnt), 32'(e[EW-1 -: DW]));
        check("out_zero", 32'(out_zero), 32'(e[TW +: LANES]));
`ifdef CLZ2_PIPE_MERGE_EN
        check("out_total", 32'(out_total), 32'(e[TW-1:0]));
`endif
        pops++;
      end
    end
  end

  // Driver: present a vector and wait (bounded) until it is accepted.
  task automatic send(input int idx);
    int   budget;
    logic ok;
    in_data  = vecs[idx].data;
    in_valid = 1'b1;
    budget   = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      budget++;
    end while (!ok && budget < 50);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<50", budget);
    end else begin
      exp_q.push_back({vecs[idx].cnt, vecs[idx].zero, vecs[idx].total});
    end
    #1;
  endtask

  initial begin
    int c0;
    int p0;
    checks   = 0;
    failures = 0;
    pops     = 0;
    cyc      = 0;
    //              data      cnt       zero   total
    vecs[0] = '{16'h0000, 16'hAAAA, 8'hFF, 5'd16};
    vecs[1] = '{16'h5555, 16'h5555, 8'h00, 5'd1};
    vecs[2] = '{16'hAAAA, 16'h0000, 8'h00, 5'd0};
    vecs[3] = '{16'hFFFF, 16'h0000, 8'h00, 5'd0};
    vecs[4] = '{16'h1B1B, 16'h9090, 8'h88, 5'd3};
    vecs[5] = '{16'h0010, 16'hAA9A, 8'hFB, 5'd11};
    vecs[6] = '{16'h8000, 16'h2AAA, 8'h7F, 5'd0};
    vecs[7] = '{16'h0001, 16'hAAA9, 8'hFE, 5'd15};
    vecs[8] = '{16'hE4E4, 16'h0606, 8'h11, 5'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_cnt", 32'(out_cnt), 32'd0);
    check("reset_out_zero", 32'(out_zero), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef CLZ2_PIPE_MERGE_EN
    check("reset_out_total", 32'(out_total), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors, one at a time
    for (int i = 0; i < 9; i++) begin
      send(i);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end

    // Streaming 16 beats back to back
    c0 = cyc;
    p0 = pops;
    for (int b = 0; b < 16; b++) send(b % 9);
    in_valid = 1'b0;
    check("stream_accept_cycles", 32'(cyc - c0), 32'd16);
    @(negedge clk);
    #1;
    check("stream_pops", 32'(pops - p0), 32'd16);

    // Backpressure: one beat held for five cycles while a second waits
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(4);
    in_data  = vecs[5].data;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_cnt", 32'(out_cnt), 32'h9090);
      check("stall_out_zero", 32'(out_zero), 32'h88);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    exp_q.push_back({vecs[5].cnt, vecs[5].zero, vecs[5].total});
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd1);
    check("release_out_cnt", 32'(out_cnt), 32'hAA9A);
    @(posedge clk);
    #1;

    // Asynchronous reset while a beat is stalled
    out_ready = 1'b0;
    send(0);
    in_valid = 1'b0;
    check("prereset_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_cnt", 32'(out_cnt), 32'd0);
    check("midreset_out_zero", 32'(out_zero), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Traffic after reset
    send(7);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
